// File: rtl/lsu_pkg.sv
// Shared types and helpers for the SRAM load/store unit.
// Misaligned-access trapping is enabled by defining LSU_MISALIGN_TRAP_EN.
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } lsu_state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Byte enables for a store; the size is encoded in funct3[1:0].
    function automatic logic [3:0] bmask_f(input logic [2:0] funct3, input logic [1:0] addr_lo);
        case (funct3[1:0])
            2'b00:   return 4'b0001 << addr_lo;
            2'b01:   return 4'b0011 << {addr_lo[1], 1'b0};
            default: return 4'b1111;
        endcase
    endfunction

    // Store data is replicated across lanes so the byte mask alone selects the target.
    function automatic logic [31:0] wdata_f(input logic [2:0] funct3, input logic [31:0] st_data);
        case (funct3[1:0])
            2'b00:   return {4{st_data[7:0]}};
            2'b01:   return {2{st_data[15:0]}};
            default: return st_data;
        endcase
    endfunction

endpackage

// File: rtl/lsu_ld_align.sv
// Load-data lane select plus sign/zero extension for RV32I loads.
module lsu_ld_align
    import lsu_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    output logic [31:0] result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata[7:0];
        case (addr_lo)
            2'd0: byte_sel = rdata[7:0];
            2'd1: byte_sel = rdata[15:8];
            2'd2: byte_sel = rdata[23:16];
            2'd3: byte_sel = rdata[31:24];
            default: byte_sel = rdata[7:0];
        endcase
        half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    end

    // funct3[2] selects zero extension; 011/110/111 fall through to a plain word.
    always_comb begin
        result = rdata;
        case (funct3[1:0])
            2'b00:   result = funct3[2] ? {24'd0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
            2'b01:   result = funct3[2] ? {16'd0, half_sel} : {{16{half_sel[15]}}, half_sel};
            default: result = rdata;
        endcase
    end

endmodule

// File: rtl/lsu_sram.sv
// Load/store unit driving a word-wide req/ack SRAM; stalls the core while an access is outstanding.
// Optional feature: LSU_MISALIGN_TRAP_EN traps misaligned half/word accesses instead of forcing alignment.
module lsu_sram
    import lsu_pkg::*;
#(
    parameter int ADDR_W      = 18,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_lsu_en,
    input  logic              i_lsu_we,
    input  logic [2:0]        i_funct3,
    input  logic [31:0]       i_addr,
    input  logic [31:0]       i_st_data,
    output logic              o_stall,
    output logic              o_ld_valid,
    output logic [31:0]       o_ld_data,
    output logic              o_err,
    output logic              o_misalign,
    output logic              o_sram_req,
    output logic              o_sram_we,
    output logic [ADDR_W-1:0] o_sram_addr,
    output logic [3:0]        o_sram_bmask,
    output logic [31:0]       o_sram_wdata,
    input  logic              i_sram_ack,
    input  logic [31:0]       i_sram_rdata
);

    localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT_CYC > 0) ? CNT_W'(TIMEOUT_CYC - 1) : '0;

    lsu_state_e         state_reg, state_next;
    logic               we_reg;
    logic [2:0]         funct3_reg;
    logic [ADDR_W+1:0]  addr_reg;
    logic [31:0]        st_data_reg;
    logic [31:0]        rdata_reg;
    logic               err_reg;
    logic               mis_reg;
    logic [CNT_W-1:0]   cnt_reg;

    logic               capture;
    logic               misaligned;
    logic               timeout_hit;
    logic               in_req;
    logic               in_done;
    logic [31:0]        aligned;

    assign capture = (state_reg == IDLE) && i_lsu_en;
    assign in_req  = (state_reg == REQ);
    assign in_done = (state_reg == DONE);

`ifdef LSU_MISALIGN_TRAP_EN
    always_comb begin
        misaligned = 1'b0;
        case (i_funct3[1:0])
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = i_addr[0];
            default: misaligned = |i_addr[1:0];
        endcase
    end
`else
    assign misaligned = 1'b0;
`endif

    // Counter value CNT_LAST means this is the TIMEOUT_CYC-th unacknowledged REQ cycle.
    assign timeout_hit = in_req && !i_sram_ack && (TIMEOUT_CYC != 0) && (cnt_reg == CNT_LAST);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (i_lsu_en) state_next = misaligned ? DONE : REQ;
            REQ:     if (i_sram_ack || timeout_hit) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_reg   <= IDLE;
            we_reg      <= 1'b0;
            funct3_reg  <= 3'd0;
            addr_reg    <= '0;
            st_data_reg <= 32'd0;
            rdata_reg   <= 32'd0;
            err_reg     <= 1'b0;
            mis_reg     <= 1'b0;
            cnt_reg     <= '0;
        end else begin
            state_reg <= state_next;
            if (capture) begin
                we_reg      <= i_lsu_we;
                funct3_reg  <= i_funct3;
                addr_reg    <= i_addr[ADDR_W+1:0];
                st_data_reg <= i_st_data;
                err_reg     <= 1'b0;
                mis_reg     <= misaligned;
                cnt_reg     <= '0;
            end
            if (in_req) begin
                if (i_sram_ack) begin
                    if (!we_reg) rdata_reg <= i_sram_rdata;
                end else begin
                    cnt_reg <= cnt_reg + 1'b1;
                end
                if (timeout_hit) err_reg <= 1'b1;
            end
        end
    end

    lsu_ld_align u_ld_align (
        .rdata   (rdata_reg),
        .funct3  (funct3_reg),
        .addr_lo (addr_reg[1:0]),
        .result  (aligned)
    );

    // SRAM-side outputs are only non-zero while a request is in flight.
    assign o_stall      = in_req || ((state_reg == IDLE) && i_lsu_en);
    assign o_sram_req   = in_req;
    assign o_sram_we    = in_req && we_reg;
    assign o_sram_addr  = in_req ? addr_reg[ADDR_W+1:2] : '0;
    assign o_sram_bmask = !in_req ? 4'b0000 : (we_reg ? bmask_f(funct3_reg, addr_reg[1:0]) : 4'b1111);
    assign o_sram_wdata = (in_req && we_reg) ? wdata_f(funct3_reg, st_data_reg) : 32'd0;

    assign o_ld_valid = in_done && !we_reg && !err_reg && !mis_reg;
    assign o_ld_data  = o_ld_valid ? aligned : 32'd0;
    assign o_err      = in_done && err_reg;

`ifdef LSU_MISALIGN_TRAP_EN
    assign o_misalign = in_done && mis_reg;
`else
    assign o_misalign = 1'b0;
`endif

endmodule

// File: tb/tb_lsu_sram.sv
module tb_lsu_sram;
    import lsu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        lsu_en, en_to, lsu_we;
    logic [2:0]  funct3;
    logic [31:0] addr, st_data;
    logic        sram_ack, ack_to;
    logic [31:0] sram_rdata;

    logic        stall, ld_valid, err, misalign, sram_req, sram_we;
    logic [31:0] ld_data, sram_wdata;
    logic [17:0] sram_addr;
    logic [3:0]  sram_bmask;

    logic        stall_to, ld_valid_to, err_to, misalign_to, req_to, we_to;
    logic [31:0] ld_data_to, wdata_to;
    logic [17:0] addr_to;
    logic [3:0]  bmask_to;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    lsu_sram dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_lsu_en(lsu_en), .i_lsu_we(lsu_we),
        .i_funct3(funct3), .i_addr(addr), .i_st_data(st_data),
        .o_stall(stall), .o_ld_valid(ld_valid), .o_ld_data(ld_data), .o_err(err),
        .o_misalign(misalign), .o_sram_req(sram_req), .o_sram_we(sram_we),
        .o_sram_addr(sram_addr), .o_sram_bmask(sram_bmask), .o_sram_wdata(sram_wdata),
        .i_sram_ack(sram_ack), .i_sram_rdata(sram_rdata)
    );

    lsu_sram #(.ADDR_W(18), .TIMEOUT_CYC(4)) dut_to (
        .i_clk(clk), .i_rst_n(rst_n), .i_lsu_en(en_to), .i_lsu_we(lsu_we),
        .i_funct3(funct3), .i_addr(addr), .i_st_data(st_data),
        .o_stall(stall_to), .o_ld_valid(ld_valid_to), .o_ld_data(ld_data_to), .o_err(err_to),
        .o_misalign(misalign_to), .o_sram_req(req_to), .o_sram_we(we_to),
        .o_sram_addr(addr_to), .o_sram_bmask(bmask_to), .o_sram_wdata(wdata_to),
        .i_sram_ack(ack_to), .i_sram_rdata(sram_rdata)
    );

    task automatic check(input string tag, input logic ok, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (ok !== 1'b1) begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic access(input logic we, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] d, input logic [31:0] rd, input int waits,
                          input logic [17:0] e_addr, input logic [3:0] e_bmask,
                          input logic [31:0] e_wdata, input logic e_valid,
                          input logic [31:0] e_data, input string tag);
        int stall_cnt;
        stall_cnt = 0;
        lsu_en = 1'b1; lsu_we = we; funct3 = f3; addr = a; st_data = d; sram_ack = 1'b0;
        #1;
        if (stall) stall_cnt++;
        @(negedge clk);
        for (int i = 0; i <= waits; i++) begin
            check({tag, "/req"},   sram_req === 1'b1,     sram_req,   1'b1);
            check({tag, "/addr"},  sram_addr === e_addr,  sram_addr,  e_addr);
            check({tag, "/bmask"}, sram_bmask === e_bmask, sram_bmask, e_bmask);
            check({tag, "/wdata"}, sram_wdata === e_wdata, sram_wdata, e_wdata);
            check({tag, "/we"},    sram_we === we,        sram_we,    we);
            if (stall) stall_cnt++;
            if (i == waits) begin
                sram_ack = 1'b1;
                sram_rdata = rd;
            end
            @(negedge clk);
        end
        sram_ack = 1'b0;
        sram_rdata = 32'hA5A5_5A5A;
        check({tag, "/done_stall"}, stall === 1'b0,     stall,    1'b0);
        check({tag, "/done_req"},   sram_req === 1'b0,  sram_req, 1'b0);
        check({tag, "/ld_valid"},   ld_valid === e_valid, ld_valid, e_valid);
        check({tag, "/ld_data"},    ld_data === e_data, ld_data,  e_data);
        check({tag, "/err"},        err === 1'b0,       err,      1'b0);
        check({tag, "/misalign"},   misalign === 1'b0,  misalign, 1'b0);
        @(negedge clk);
        check({tag, "/pulse_end"},  ld_valid === 1'b0,  ld_valid, 1'b0);
        check({tag, "/no_reissue"}, sram_req === 1'b0,  sram_req, 1'b0);
        lsu_en = 1'b0;
        check({tag, "/stall_cycles"}, stall_cnt == waits + 2, stall_cnt, waits + 2);
        $display("txn %s we=%0b f3=%0b addr=%h waits=%0d stall_cycles=%0d", tag, we, f3, a, waits, stall_cnt);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; lsu_en = 1'b0; en_to = 1'b0; lsu_we = 1'b0; funct3 = 3'd0;
        addr = 32'd0; st_data = 32'd0; sram_ack = 1'b0; ack_to = 1'b0;
        sram_rdata = 32'hA5A5_5A5A;
        repeat (2) @(negedge clk);
        check("rst/stall",    stall === 1'b0,        stall,      1'b0);
        check("rst/req",      sram_req === 1'b0,     sram_req,   1'b0);
        check("rst/ld_valid", ld_valid === 1'b0,     ld_valid,   1'b0);
        check("rst/ld_data",  ld_data === 32'd0,     ld_data,    32'd0);
        check("rst/err",      err === 1'b0,          err,        1'b0);
        check("rst/bmask",    sram_bmask === 4'd0,   sram_bmask, 4'd0);
        check("rst/addr",     sram_addr === 18'd0,   sram_addr,  18'd0);
        rst_n = 1'b1;
        @(negedge clk);

        access(1'b1, F3_W,  32'h100, 32'hDEADBEEF, 32'd0,        0, 18'h40, 4'b1111, 32'hDEADBEEF, 1'b0, 32'd0,        "SW");
        access(1'b0, F3_B,  32'h103, 32'd0,        32'h80112233, 0, 18'h40, 4'b1111, 32'd0,        1'b1, 32'hFFFFFF80, "LB");
        access(1'b0, F3_BU, 32'h103, 32'd0,        32'h80112233, 0, 18'h40, 4'b1111, 32'd0,        1'b1, 32'h00000080, "LBU");
        access(1'b1, F3_H,  32'h202, 32'h0000ABCD, 32'd0,        0, 18'h80, 4'b1100, 32'hABCDABCD, 1'b0, 32'd0,        "SH");
        access(1'b0, F3_H,  32'h202, 32'd0,        32'h7FFF0000, 0, 18'h80, 4'b1111, 32'd0,        1'b1, 32'h00007FFF, "LH");
        access(1'b1, F3_B,  32'h001, 32'h0000005A, 32'd0,        0, 18'h00, 4'b0010, 32'h5A5A5A5A, 1'b0, 32'd0,        "SB");
        access(1'b0, F3_HU, 32'h206, 32'd0,        32'h80010000, 5, 18'h81, 4'b1111, 32'd0,        1'b1, 32'h00008001, "LHU_wait5");

        en_to = 1'b1; lsu_we = 1'b0; funct3 = F3_W; addr = 32'h300;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            check("TO/req",       req_to === 1'b1, req_to, 1'b1);
            check("TO/err_early", err_to === 1'b0, err_to, 1'b0);
            @(negedge clk);
        end
        check("TO/req_dropped", req_to === 1'b0,       req_to,      1'b0);
        check("TO/err",         err_to === 1'b1,       err_to,      1'b1);
        check("TO/ld_valid",    ld_valid_to === 1'b0,  ld_valid_to, 1'b0);
        check("TO/ld_data",     ld_data_to === 32'd0,  ld_data_to,  32'd0);
        check("TO/stall",       stall_to === 1'b0,     stall_to,    1'b0);
        @(negedge clk);
        check("TO/err_pulse", err_to === 1'b0, err_to, 1'b0);
        en_to = 1'b0;
        $display("txn TO lw addr=%h no-ack abort", 32'h300);

        lsu_en = 1'b1; lsu_we = 1'b0; funct3 = F3_W; addr = 32'h400;
        @(negedge clk);
        check("RST_REQ/req_before", sram_req === 1'b1, sram_req, 1'b1);
        rst_n = 1'b0; lsu_en = 1'b0;
        @(negedge clk);
        check("RST_REQ/req",      sram_req === 1'b0, sram_req, 1'b0);
        check("RST_REQ/stall",    stall === 1'b0,    stall,    1'b0);
        check("RST_REQ/ld_valid", ld_valid === 1'b0, ld_valid, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);
        check("RST_REQ/idle_req",   sram_req === 1'b0, sram_req, 1'b0);
        check("RST_REQ/idle_valid", ld_valid === 1'b0, ld_valid, 1'b0);
        check("RST_REQ/idle_err",   err === 1'b0,      err,      1'b0);
        $display("txn RST_REQ reset during REQ");

`ifdef LSU_MISALIGN_TRAP_EN
        lsu_en = 1'b1; lsu_we = 1'b0; funct3 = F3_W; addr = 32'h101;
        @(negedge clk);
        check("MIS/req",      sram_req === 1'b0, sram_req, 1'b0);
        check("MIS/misalign", misalign === 1'b1, misalign, 1'b1);
        check("MIS/ld_valid", ld_valid === 1'b0, ld_valid, 1'b0);
        check("MIS/stall",    stall === 1'b0,    stall,    1'b0);
        @(negedge clk);
        check("MIS/pulse_end", misalign === 1'b0, misalign, 1'b0);
        check("MIS/no_req",    sram_req === 1'b0, sram_req, 1'b0);
        lsu_en = 1'b0;
        $display("txn MIS lw addr=%h trapped", 32'h101);
`else
        access(1'b0, F3_W, 32'h101, 32'd0, 32'h12345678, 0, 18'h40, 4'b1111, 32'd0, 1'b1, 32'h12345678, "LW_unaligned");
`endif

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
